// File: rtl/aes_decrypt_core_pkg.sv
// Shared AES definitions for the inverse cipher: sizes, FSM encoding,
// the inverse S-box table and GF(2^8) helpers built from xtime chains.
package aes_decrypt_core_pkg;

   localparam int AES_BLOCK = 128;
   localparam int AES256_NR = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) using shifted xtime terms.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
   endfunction

endpackage

// File: rtl/aes_decrypt_core_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
   import aes_decrypt_core_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_key,
   input  logic         i_last,
   output logic [127:0] o_next
);

   logic [7:0]   w_in  [16];
   logic [7:0]   w_sr  [16];
   logic [7:0]   w_ark [16];
   logic [7:0]   w_mc  [16];
   logic [127:0] w_ark_flat;
   logic [127:0] w_mc_flat;

   // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
   always_comb begin
      w_in       = '{default: 8'h00};
      w_sr       = '{default: 8'h00};
      w_ark      = '{default: 8'h00};
      w_mc       = '{default: 8'h00};
      w_ark_flat = 128'h0;
      w_mc_flat  = 128'h0;
      for (int k = 0; k < 16; k++) begin
         w_in[k] = i_state[127-8*k -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_sr[4*c+r] = w_in[4*((c-r+4)%4)+r];
         end
      end
      for (int k = 0; k < 16; k++) begin
         w_ark[k] = inv_sbox(w_sr[k]) ^ i_key[127-8*k -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         w_mc[4*c+0] = gmul(w_ark[4*c], 4'he) ^ gmul(w_ark[4*c+1], 4'hb)
                     ^ gmul(w_ark[4*c+2], 4'hd) ^ gmul(w_ark[4*c+3], 4'h9);
         w_mc[4*c+1] = gmul(w_ark[4*c], 4'h9) ^ gmul(w_ark[4*c+1], 4'he)
                     ^ gmul(w_ark[4*c+2], 4'hb) ^ gmul(w_ark[4*c+3], 4'hd);
         w_mc[4*c+2] = gmul(w_ark[4*c], 4'hd) ^ gmul(w_ark[4*c+1], 4'h9)
                     ^ gmul(w_ark[4*c+2], 4'he) ^ gmul(w_ark[4*c+3], 4'hb);
         w_mc[4*c+3] = gmul(w_ark[4*c], 4'hb) ^ gmul(w_ark[4*c+1], 4'hd)
                     ^ gmul(w_ark[4*c+2], 4'h9) ^ gmul(w_ark[4*c+3], 4'he);
      end
      for (int k = 0; k < 16; k++) begin
         w_ark_flat[127-8*k -: 8] = w_ark[k];
         w_mc_flat[127-8*k -: 8]  = w_mc[k];
      end
      if (i_last) begin
         o_next = w_ark_flat;
      end else begin
         o_next = w_mc_flat;
      end
   end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-256 inverse cipher: one inverse round per key-qualified cycle,
// round keys requested from the key store in descending order NR..0.
module aes_decrypt_core
   import aes_decrypt_core_pkg::*;
#(
   parameter int DATA_WIDTH = AES_BLOCK,
   parameter int NR         = AES256_NR
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] round_key,
   input  logic                  round_key_rdy,
   output logic [3:0]            round_key_addr,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam logic [3:0] RND_FIRST = 4'(NR);

   state_t                r_fsm;
   state_t                w_fsm_nxt;
   logic [3:0]            r_rnd;
   logic [3:0]            w_rnd_nxt;
   logic [DATA_WIDTH-1:0] r_state;
   logic [DATA_WIDTH-1:0] w_state_nxt;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] w_dout_nxt;
   logic [DATA_WIDTH-1:0] w_round_out;
   logic                  r_busy;
   logic                  r_done;

   aes_inv_round u_round (
      .i_state (r_state),
      .i_key   (round_key),
      .i_last  (r_rnd == 4'd0),
      .o_next  (w_round_out)
   );

   // Next-state, round counter and datapath update.
   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_rnd_nxt   = r_rnd;
      w_state_nxt = r_state;
      w_dout_nxt  = r_dout;
      case (r_fsm)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_fsm_nxt   = ST_RUN;
               w_state_nxt = data_in;
               w_rnd_nxt   = RND_FIRST;
            end else begin
               w_fsm_nxt   = r_fsm;
            end
         end
         ST_RUN: begin
            if (!round_key_rdy) begin
               w_fsm_nxt = ST_RUN;
            end else if (r_rnd == RND_FIRST) begin
               w_state_nxt = r_state ^ round_key;
               w_rnd_nxt   = r_rnd - 4'd1;
            end else if (r_rnd == 4'd0) begin
               w_dout_nxt  = w_round_out;
               w_fsm_nxt   = ST_DONE;
            end else begin
               w_state_nxt = w_round_out;
               w_rnd_nxt   = r_rnd - 4'd1;
            end
         end
         default: begin
            w_fsm_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_fsm <= ST_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // Datapath registers and registered status flags.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_rnd   <= RND_FIRST;
         r_state <= '0;
         r_dout  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_rnd   <= w_rnd_nxt;
         r_state <= w_state_nxt;
         r_dout  <= w_dout_nxt;
         r_busy  <= (w_fsm_nxt == ST_RUN);
         r_done  <= (w_fsm_nxt == ST_DONE);
      end
   end

   assign round_key_addr = r_rnd;
   assign busy           = r_busy;
   assign done           = r_done;
   assign data_out       = r_dout;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: FIPS-197 C.3 vectors plus random round trips
// through a forward-cipher reference model with a bench-side key store.
module tb_aes_decrypt_core;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         start;
   logic [127:0] data_in;
   logic [127:0] round_key;
   logic         round_key_rdy;
   logic [3:0]   round_key_addr;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   logic [127:0] ks [16];
   logic [127:0] junk;
   logic [7:0]   sbox [256];
   int checks = 0;
   int errors = 0;

   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

   always #5 Clk = ~Clk;

   assign round_key = round_key_rdy ? ks[round_key_addr] : junk;

   aes_decrypt_core dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .start          (start),
      .data_in        (data_in),
      .round_key      (round_key),
      .round_key_rdy  (round_key_rdy),
      .round_key_addr (round_key_addr),
      .busy           (busy),
      .done           (done),
      .data_out       (data_out)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      int p = 0;
      int x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
         if (x > 255) x = (x ^ 'h11b);
      end
      return p[7:0];
   endfunction

   function automatic int rotl8(input int b, input int n);
      return ((b << n) | (b >> (8 - n))) & 255;
   endfunction

   // Forward S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         int inv = 0;
         for (int y = 1; y < 256 && x != 0; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = y;
         end
         sbox[x] = 8'(inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63);
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   // AES-256 key schedule; fills the bench key store with round keys 0..14.
   task automatic load_key(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gf_mul(rcon, 8'h02);
         end else if (i % 8 == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      ks[15] = 128'h0;
   endtask

   // Forward cipher using the current key store.
   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] res;
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[0][127-8*k -: 8];
      for (int rnd = 1; rnd <= 14; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = sbox[s[4*((c+r)%4)+r]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 14) begin
               s[4*c+0] = gf_mul(t[4*c], 8'h02) ^ gf_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1], 8'h02) ^ gf_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2], 8'h02) ^ gf_mul(t[4*c+3], 8'h03);
               s[4*c+3] = gf_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
            end
         end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[rnd][127-8*k -: 8];
      end
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
      return res;
   endfunction

   // Runs one block from a negedge; mode bit0 = random stalls, bit1 = stray start pulses.
   task automatic run_block(input logic [127:0] ct, input int mode, output logic [127:0] res,
                            output int lat, output int stalls, output bit addr_ok);
      int exp_addr = 14;
      data_in = ct;
      start = 1'b1;
      round_key_rdy = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      start = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      lat = 1;
      stalls = 0;
      addr_ok = 1'b1;
      while (!done && lat < 200) begin
         if (round_key_addr != 4'(exp_addr) || !busy) addr_ok = 1'b0;
         start = ((mode & 2) != 0 && (lat == 3 || lat == 9));
         round_key_rdy = ((mode & 1) != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
         junk = {$urandom, $urandom, $urandom, $urandom};
         @(posedge Clk);
         if (round_key_rdy) begin
            if (exp_addr > 0) exp_addr--;
         end else begin
            stalls++;
         end
         lat++;
         @(negedge Clk);
      end
      start = 1'b0;
      round_key_rdy = 1'b1;
      res = data_out;
   endtask

   typedef struct {
      logic [255:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           mode;
   } vec_t;

   initial begin
      vec_t         tbl [5];
      logic [127:0] res;
      logic [127:0] pt;
      logic [255:0] key;
      int           lat;
      int           stalls;
      bit           addr_ok;
      int           wait_n;

      Rst = 1'b0;
      start = 1'b0;
      data_in = 128'h0;
      round_key_rdy = 1'b1;
      junk = 128'h0;
      build_sbox();

      tbl[0] = '{C3_KEY, C3_CT, C3_PT, 0};
      tbl[1] = '{C3_KEY, C3_CT, C3_PT, 1};
      tbl[2] = '{C3_KEY, C3_CT, C3_PT, 2};
      load_key(256'h0);
      tbl[3] = '{256'h0, encrypt(128'h0), 128'h0, 0};
      load_key({256{1'b1}});
      tbl[4] = '{{256{1'b1}}, encrypt({128{1'b1}}), {128{1'b1}}, 1};

      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      check("reset_busy", 128'(busy), 128'h0);
      check("reset_done", 128'(done), 128'h0);
      check("reset_data_out", data_out, 128'h0);
      check("reset_addr", 128'(round_key_addr), 128'd14);

      for (int i = 0; i < 5; i++) begin
         load_key(tbl[i].key);
         run_block(tbl[i].ct, tbl[i].mode, res, lat, stalls, addr_ok);
         check($sformatf("vec%0d_data_out", i), res, tbl[i].pt);
         check($sformatf("vec%0d_latency", i), 128'(lat), 128'(16 + stalls));
         check($sformatf("vec%0d_addr_seq", i), 128'(addr_ok), 128'h1);
         check($sformatf("vec%0d_done", i), 128'(done), 128'h1);
         check($sformatf("vec%0d_busy", i), 128'(busy), 128'h0);
      end

      // Back-to-back relaunch straight from DONE.
      load_key(C3_KEY);
      run_block(C3_CT, 0, res, lat, stalls, addr_ok);
      check("b2b_data_out", res, C3_PT);
      check("b2b_latency", 128'(lat), 128'd16);

      // Reset while round 7 is in flight.
      data_in = C3_CT;
      start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      start = 1'b0;
      wait_n = 0;
      while (round_key_addr != 4'd7 && wait_n < 40) begin
         @(negedge Clk);
         wait_n++;
      end
      check("midreset_reached_r7", 128'(round_key_addr), 128'd7);
      Rst = 1'b0;
      #1;
      check("midreset_busy", 128'(busy), 128'h0);
      check("midreset_done", 128'(done), 128'h0);
      check("midreset_data_out", data_out, 128'h0);
      check("midreset_addr", 128'(round_key_addr), 128'd14);
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      run_block(C3_CT, 0, res, lat, stalls, addr_ok);
      check("postreset_data_out", res, C3_PT);
      check("postreset_latency", 128'(lat), 128'd16);

      // Random round trips through the reference encrypt model.
      for (int n = 0; n < 1000; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         run_block(encrypt(pt), (n % 4 == 3) ? 1 : 0, res, lat, stalls, addr_ok);
         check($sformatf("rt%0d_data_out", n), res, pt);
         if (n % 50 == 0) begin
            check($sformatf("rt%0d_latency", n), 128'(lat), 128'(16 + stalls));
            check($sformatf("rt%0d_addr_seq", n), 128'(addr_ok), 128'h1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
